seq_shifter: RTL and testbench

SEQ_SHIFTER -- requirements
Module: seq_shifter

---
 rtl/seq_shifter.sv | 113 +++++++++++
 tb/tb_seq_shifter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle barrel-free shifter, STEP bit positions per cycle.
// Optional rotate-left for mode 11 when SEQ_SHIFTER_ROTATE_EN is defined.
module seq_shifter #(
    parameter int WIDTH = 17,
    parameter int AMT_W = 5,
    parameter int STEP  = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] data_i,
    input  logic [AMT_W-1:0] amt_i,
    input  logic [1:0]       mode_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] data_o
);

    // A per-cycle step larger than the amount field can hold behaves as
    // "shift everything that remains", so clamp it to the field range.
    localparam int AMT_MAX = (1 << AMT_W) - 1;
    localparam int STEP_C  = (STEP > AMT_MAX) ? AMT_MAX : STEP;
    localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP_C);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_work;
    logic [AMT_W-1:0] r_rem;
    logic [1:0]       r_mode;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [AMT_W-1:0] w_s;
    logic [WIDTH-1:0] w_shifted;

    assign w_s         = (r_rem < STEP_A) ? r_rem : STEP_A;
    assign data_o      = r_work;
    assign in_ready_o  = r_in_ready;
    assign out_valid_o = r_out_valid;

    // One step of the captured operation applied to the working register.
    always_comb begin
        w_shifted = r_work;
        case (r_mode)
            2'b00: w_shifted = r_work << w_s;
            2'b01: w_shifted = r_work >> w_s;
            2'b10: w_shifted = $signed(r_work) >>> w_s;
`ifdef SEQ_SHIFTER_ROTATE_EN
            2'b11: w_shifted = (r_work << w_s) |
                               (r_work >> (32'(WIDTH) - 32'(w_s)));
`else
            2'b11: w_shifted = r_work << w_s;
`endif
            default: w_shifted = r_work;
        endcase
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= IDLE;
            r_work      <= '0;
            r_rem       <= '0;
            r_mode      <= 2'b00;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid_i) begin
                        r_work     <= data_i;
                        r_mode     <= mode_i;
                        r_rem      <= amt_i;
                        r_in_ready <= 1'b0;
                        if (amt_i == '0) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    r_work <= w_shifted;
                    r_rem  <= r_rem - w_s;
                    if (r_rem == w_s) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: STEP=1 and STEP=2 instances driven in lockstep and
// compared every cycle against a whole-operation reference model.
module tb_seq_shifter;

    localparam int W  = 17;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [W-1:0]  din;
    logic [AW-1:0] amt;
    logic [1:0]    mode;
    logic          out_ready;
    logic          rdy  [2];
    logic          vld  [2];
    logic [W-1:0]  dout [2];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int           m_phase [2] = '{0, 0};
    int           m_cnt   [2] = '{0, 0};
    logic [W-1:0] m_exp   [2] = '{'0, '0};

    always #5 clk = ~clk;

    seq_shifter #(.WIDTH(W), .AMT_W(AW), .STEP(1)) u_s1 (
        .clk_i(clk), .rst_n_i(rst_n),
        .in_valid_i(in_valid), .in_ready_o(rdy[0]),
        .data_i(din), .amt_i(amt), .mode_i(mode),
        .out_valid_o(vld[0]), .out_ready_i(out_ready),
        .data_o(dout[0])
    );

    seq_shifter #(.WIDTH(W), .AMT_W(AW), .STEP(2)) u_s2 (
        .clk_i(clk), .rst_n_i(rst_n),
        .in_valid_i(in_valid), .in_ready_o(rdy[1]),
        .data_i(din), .amt_i(amt), .mode_i(mode),
        .out_valid_o(vld[1]), .out_ready_i(out_ready),
        .data_o(dout[1])
    );

    function automatic int step_of(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    // Full result of shifting d by a, defined bit by bit from its source.
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d,
                                               input int a,
                                               input logic [1:0] m);
        logic [W-1:0] r;
        int src;
        r = '0;
        for (int i = 0; i < W; i++) begin
`ifdef SEQ_SHIFTER_ROTATE_EN
            if (m == 2'b11) begin
                src  = (i - (a % W) + W) % W;
                r[i] = d[src];
                continue;
            end
`endif
            if (m == 2'b01 || m == 2'b10) begin
                src = i + a;
                if (src < W) r[i] = d[src];
                else         r[i] = (m == 2'b10) ? d[W-1] : 1'b0;
            end else begin
                src = i - a;
                r[i] = (src >= 0) ? d[src] : 1'b0;
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input int inst,
                         input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d actual %h expected %h t=%0t",
                     name, inst, act, exp, $time);
        end
    endtask

    // Reference model: acceptance, ceil(amt/STEP) busy cycles, result hold.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_phase[i] <= 0;
                m_cnt[i]   <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                case (m_phase[i])
                    0: if (in_valid) begin
                        m_exp[i]   <= ref_shift(din, int'(amt), mode);
                        m_cnt[i]   <= (int'(amt) + step_of(i) - 1) / step_of(i);
                        m_phase[i] <= (amt == '0) ? 2 : 1;
                    end
                    1: begin
                        m_cnt[i] <= m_cnt[i] - 1;
                        if (m_cnt[i] == 1) m_phase[i] <= 2;
                    end
                    default: if (out_ready) m_phase[i] <= 0;
                endcase
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check("in_ready", i, W'(rdy[i]), W'(m_phase[i] == 0));
                check("out_valid", i, W'(vld[i]), W'(m_phase[i] == 2));
                if (m_phase[i] == 2) check("data_o", i, dout[i], m_exp[i]);
            end
        end
    end

    task automatic start_req(input logic [W-1:0] d, input int a,
                             input logic [1:0] m, input bit keep);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (rdy[0] && rdy[1]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL start_timeout actual busy required ready");
        end
        din      = d;
        amt      = AW'(a);
        mode     = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic finish_req(input int l0, input int l1,
                              input logic [W-1:0] e, input int hold,
                              input bit junk);
        int lat  [2];
        bit seen [2];
        int lexp [2];
        lat  = '{0, 0};
        seen = '{1'b0, 1'b0};
        lexp = '{l0, l1};
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (junk) begin
                din  = W'($urandom);
                amt  = AW'($urandom);
                mode = 2'($urandom);
            end
            for (int i = 0; i < 2; i++) begin
                if (!seen[i] && vld[i]) begin
                    seen[i] = 1'b1;
                    lat[i]  = c;
                end
            end
            if (seen[0] && seen[1]) break;
        end
        for (int i = 0; i < 2; i++) begin
            if (!seen[i]) begin
                checks++;
                errors++;
                $display("FAIL done_timeout inst%0d actual no out_valid", i);
            end else begin
                check("latency", i, W'(lat[i]), W'(lexp[i]));
                check("result", i, dout[i], e);
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                check("hold_valid", i, W'(vld[i]), W'(1));
                check("hold_data", i, dout[i], e);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run(input logic [W-1:0] d, input int a,
                       input logic [1:0] m, input logic [W-1:0] e,
                       input int hold);
        start_req(d, a, m, 1'b0);
        finish_req(a, (a + 1) / 2, e, hold, 1'b0);
    endtask

    initial begin
        logic [W-1:0] rot_exp;
        logic [W-1:0] rd;
        int           ra;
        logic [1:0]   rm;
        bit           any_vld;
`ifdef SEQ_SHIFTER_ROTATE_EN
        rot_exp = 17'h00003;
`else
        rot_exp = 17'h00002;
`endif
        in_valid  = 1'b0;
        din       = '0;
        amt       = '0;
        mode      = 2'b00;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_ready", i, W'(rdy[i]), W'(1));
            check("rst_valid", i, W'(vld[i]), W'(0));
            check("rst_data", i, dout[i], '0);
        end
        chk_en = 1'b1;

        check("model_lsl", 0, ref_shift(17'h000A5, 3, 2'b00), 17'h00528);
        check("model_asr", 0, ref_shift(17'h10000, 5, 2'b10), 17'h1F800);
        check("model_lsr", 0, ref_shift(17'h10000, 5, 2'b01), 17'h00800);
        check("model_amt0", 0, ref_shift(17'h1FFFF, 0, 2'b10), 17'h1FFFF);
        check("model_big", 0, ref_shift(17'h1FFFF, 20, 2'b00), 17'h00000);
        check("model_mode3", 0, ref_shift(17'h10001, 1, 2'b11), rot_exp);

        // Request presented during reset is taken on the first edge after.
        din      = 17'h000A5;
        amt      = 5'd3;
        mode     = 2'b00;
        in_valid = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        finish_req(3, 2, 17'h00528, 2, 1'b0);

        run(17'h10000, 5, 2'b10, 17'h1F800, 0);
        run(17'h10000, 5, 2'b01, 17'h00800, 0);
        for (int m = 0; m < 4; m++)
            run(17'h1FFFF, 0, 2'(m), 17'h1FFFF, 0);
        run(17'h1FFFF, 20, 2'b00, 17'h00000, 0);
        run(17'h10001, 1, 2'b11, rot_exp, 0);
        run(17'h1ABCD, 31, 2'b10, 17'h1FFFF, 1);
        run(17'h0ABCD, 31, 2'b10, 17'h00000, 0);

        // Asynchronous reset pulse in the middle of a shift.
        start_req(17'h01234, 20, 2'b00, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("pulse_ready", i, W'(rdy[i]), W'(1));
            check("pulse_valid", i, W'(vld[i]), W'(0));
        end
        #1 rst_n = 1'b1;
        any_vld = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (vld[0] || vld[1]) any_vld = 1'b1;
        end
        check("no_ghost_result", 0, W'(any_vld), W'(0));
        run(17'h00F0F, 4, 2'b00, 17'h0F0F0, 0);

        // in_valid held high with changing inputs while busy.
        start_req(17'h1E000, 7, 2'b01, 1'b1);
        finish_req(7, 4, 17'h003C0, 1, 1'b1);
        start_req(17'h00F0F, 4, 2'b00, 1'b0);
        finish_req(4, 2, 17'h0F0F0, 0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            rd = W'($urandom);
            ra = int'($urandom_range(0, 31));
            rm = 2'($urandom);
            start_req(rd, ra, rm, 1'b0);
            finish_req(ra, (ra + 1) / 2, ref_shift(rd, ra, rm),
                       int'($urandom_range(0, 3)), ($urandom % 4) == 0);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
